// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [15:0] PS2_KBD_PORT = 16'h0082;

  // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_scan_fifo.sv
// Synchronous first-word-fall-through scan-code queue with push, pop, flush and occupancy count.
module ps2_scan_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [7:0]             push_dat_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [7:0]             head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  // A pop on a full queue frees the slot the same-cycle push needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame decode, scan codes into a FWFT queue.
// PS2_TIMEOUT_EN adds an idle watchdog that aborts a stalled partial frame.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 16
`ifdef PS2_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 200000
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk_i,
  input  logic                        ps2_data_i,
  input  logic                        rd_pop,
  input  logic                        flush,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err
);

  // Bit 0 carries the PS/2 clock line, bit 1 the data line.
  logic [1:0] pin;
  logic [1:0] s1_q, s2_q, flt_q;
  logic [4:0] flt_cnt_q [2];
  logic       clk_prev_q;
  logic       fe;
  logic       dat;

  ps2_state_t state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       par_q, par_d;
  logic       push, err_set;
  logic       frame_err_q, overflow_q;
  logic       fifo_full, fifo_empty;

  assign pin = {ps2_data_i, ps2_clk_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 2'b11;
      s2_q       <= 2'b11;
      flt_q      <= 2'b11;
      flt_cnt_q  <= '{default: '0};
      clk_prev_q <= 1'b1;
    end else begin
      s1_q       <= pin;
      s2_q       <= s1_q;
      clk_prev_q <= flt_q[0];
      for (int i = 0; i < 2; i++) begin
        // A new level is adopted only once FILTER_LEN consecutive samples agree on it.
        if (s2_q[i] != flt_q[i]) begin
          if (flt_cnt_q[i] == 5'(FILTER_LEN - 1)) begin
            flt_q[i]     <= s2_q[i];
            flt_cnt_q[i] <= '0;
          end else begin
            flt_cnt_q[i] <= flt_cnt_q[i] + 5'd1;
          end
        end else begin
          flt_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign fe  = clk_prev_q & ~flt_q[0];
  assign dat = flt_q[1];

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_q;
  logic          timeout_hit;

  assign timeout_hit = (state_q != IDLE) && !fe && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || fe || state_q == IDLE) idle_cnt_q <= '0;
    else                              idle_cnt_q <= idle_cnt_q + TW'(1);
  end
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    push     = 1'b0;
    err_set  = 1'b0;
    if (fe) begin
      case (state_q)
        IDLE: begin
          if (!dat) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end else begin
            err_set = 1'b1;
          end
        end
        DATA: begin
          shreg_d  = {dat, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat;
          state_d = STOP;
        end
        default: begin
          if (dat && odd_parity_ok(shreg_q, par_q)) push = 1'b1;
          else                                      err_set = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    if (timeout_hit) begin
      state_d = IDLE;
      err_set = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
    end
  end

  // Flush clears the sticky flags but leaves the frame decoder running.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (err_set)                      frame_err_q <= 1'b1;
      if (push && fifo_full && !rd_pop) overflow_q  <= 1'b1;
    end
  end

  ps2_scan_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .push_dat_i(shreg_q),
    .pop_i     (rd_pop),
    .flush_i   (flush),
    .head_o    (rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rd_valid  = ~fifo_empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: host-driven PS/2 frames, expected codes queued and compared on pop.
module tb_ps2_kbd_rx;

  localparam int TO = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_data;
  logic       rd_pop, flush;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] fifo_count;
  logic       overflow, frame_err;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FILTER_LEN(8),
    .FIFO_DEPTH(16)
`ifdef PS2_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .rd_pop    (rd_pop),
    .flush     (flush),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  int         errs = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic       exp_err = 1'b0;
  logic       exp_ovf = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // bits[0] is the start bit; odd parity bit is the inverted XOR of the data.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_start, input logic bad_par);
    return {1'b1, (~^d) ^ bad_par, d, bad_start};
  endfunction

  // Each bit: data set mid-high, clock low for 32 cycles, clock high again.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(16);
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        // Sync (2) + filter (8) puts the stop-bit push on the edge after the 10th cycle.
        tick(10);
        rd_pop = 1'b1;
        tick(1);
        rd_pop = 1'b0;
        tick(21);
      end else begin
        tick(32);
      end
      ps2_clk = 1'b1;
      tick(16);
    end
    ps2_data = 1'b1;
    tick(4);
  endtask

  task automatic send_code(input logic [7:0] d);
    send_bits(mk_frame(d, 1'b0, 1'b0), 11, 1'b0);
    if (exp_q.size() < 16) exp_q.push_back(d);
    else                   exp_ovf = 1'b1;
  endtask

  task automatic chk_state(input string tag);
    chk_eq({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
    chk_eq({tag, "_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
    chk_eq({tag, "_data"}, 32'(rd_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    chk_eq({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk_eq({tag, "_ferr"}, 32'(frame_err), 32'(exp_err));
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk_eq({tag, "_valid"}, 32'(rd_valid), 32'h1);
    chk_eq({tag, "_data"}, 32'(rd_data), 32'(e));
    rd_pop = 1'b1;
    tick(1);
    rd_pop = 1'b0;
    tick(1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    tick(1);
  endtask

  initial begin
    repeat (80000) @(posedge clk);
    errs++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_pop   = 1'b0;
    flush    = 1'b0;
    tick(5);
    chk_state("reset");
    rst = 1'b0;
    tick(20);

    // Two good frames, drained in order.
    send_code(8'hAA);
    send_code(8'hBB);
    chk_state("t1");
    pop_chk("t1_pop_aa");
    pop_chk("t1_pop_bb");
    chk_state("t1_end");

    // Bad start bit; its data bits restart a frame that ends in STOP, one high bit closes it with an error.
    send_bits(mk_frame(8'hAA, 1'b1, 1'b0), 11, 1'b0);
    exp_err = 1'b1;
    send_bits(11'h7FF, 11, 1'b0);
    chk_state("t2_err");
    do_flush();
    chk_state("t2_flush");

    send_code(8'hCC);
    send_code(8'hDD);
    chk_state("t3");
    pop_chk("t3_pop_cc");
    pop_chk("t3_pop_dd");

    // Parity error drops 0x55, the following 0x12 still lands.
    send_bits(mk_frame(8'h55, 1'b0, 1'b1), 11, 1'b0);
    exp_err = 1'b1;
    send_code(8'h12);
    chk_state("t4");
    pop_chk("t4_pop_12");
    chk_state("t4_end");

    // Fill to full, push+pop at full, then a dropped push.
    for (int i = 0; i < 16; i++) send_code(8'(i));
    chk_state("t5_full");
    send_bits(mk_frame(8'h10, 1'b0, 1'b0), 11, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h10);
    chk_state("t5_pushpop");
    send_code(8'h11);
    chk_state("t5_ovf");
    for (int i = 0; i < 16; i++) pop_chk($sformatf("t5_drain%0d", i));
    rd_pop = 1'b1;
    tick(1);
    rd_pop = 1'b0;
    tick(1);
    chk_state("t5_underflow");

    // Partial frame followed by a long idle gap, then a full frame.
    do_flush();
    chk_state("t6_flush");
    send_bits(mk_frame(8'hAA, 1'b0, 1'b0), 5, 1'b0);
    tick(TO + 500);
`ifdef PS2_TIMEOUT_EN
    exp_err = 1'b1;
`endif
    chk_state("t6_idle");
`ifdef PS2_TIMEOUT_EN
    send_code(8'h5A);
    chk_state("t6_frame");
    pop_chk("t6_pop_5a");
`else
    // The leftover bits misalign 0x5A: the decoder hits a failing stop check and nothing is queued.
    send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 11, 1'b0);
    exp_err = 1'b1;
    chk_state("t6_corrupt");
`endif

    // Reset mid-frame discards the partial frame.
    send_bits(mk_frame(8'h77, 1'b0, 1'b0), 4, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    tick(3);
    chk_state("t7_rst");
    rst = 1'b0;
    tick(20);
    send_code(8'h33);
    chk_state("t7_frame");
    pop_chk("t7_pop_33");
    chk_state("t7_end");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
